dense_out: RTL

Final fully connected layer of the digit-recognition pipeline. It reads the 250 pooled activations that the second pooling stage writes into temp memory (10 channels × 5×5, address = channel·25 + step). It multiplies them against a weight ROM, adds per-class bias, and writes 10 class scores to an output RAM. It also reports the argmax digit and pulses `ready` when it finishes.

---
 rtl/nn_pkg.sv | 30 +++
 rtl/dense_out_if.sv | 30 +++
 rtl/mac_unit.sv | 31 +++
 rtl/dense_out.sv | 98 +++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and saturation helper for the digit
// recognition pipeline (dense, pooling and convolution stages).
package nn_pkg;

  localparam int N_IN  = 250;
  localparam int N_OUT = 10;
  localparam int FRAC  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK_OUT,
    LOAD_BIAS,
    MAC,
    DRAIN,
    SAVE,
    DONE
  } state_e;

  // Clamp a wide signed value into the 32-bit Q16.16 range.
  function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
    if (x > 64'sh0000_0000_7FFF_FFFF) begin
      return 32'sh7FFF_FFFF;
    end else if (x < -64'sh0000_0000_8000_0000) begin
      return 32'sh8000_0000;
    end else begin
      return x[31:0];
    end
  endfunction

endpackage

// File: rtl/dense_out_if.sv
// Memory-side and control bundle of the dense output layer: activation,
// weight and bias reads, score writes, start/ready and the argmax digit.
interface dense_out_if;

  logic               start;
  logic [13:0]        temp_rdaddr;
  logic signed [31:0] temp_q;
  logic [11:0]        weight_addr;
  logic signed [31:0] weight_q;
  logic [3:0]         bias_addr;
  logic signed [31:0] bias_q;
  logic [3:0]         out_addr;
  logic signed [31:0] out_data;
  logic               out_wren;
  logic [3:0]         digit;
  logic               ready;

  modport master (
    input  start, temp_q, weight_q, bias_q,
    output temp_rdaddr, weight_addr, bias_addr,
    output out_addr, out_data, out_wren, digit, ready
  );

  modport slave (
    output start, temp_q, weight_q, bias_q,
    input  temp_rdaddr, weight_addr, bias_addr,
    input  out_addr, out_data, out_wren, digit, ready
  );

endinterface

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: 32x32 product added into a 64-bit register
// that can instead be loaded with a bias scaled to the product's format.
module mac_unit #(
  parameter int DATA_W = 32,
  parameter int FRAC   = 16
) (
  input  logic                       Clk,
  input  logic                       load,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   bias,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] acc
);

  localparam int AW = 2 * DATA_W;

  logic signed [AW-1:0] prod;

  assign prod = AW'(a) * AW'(b);

  // Accumulator register; wraps modulo 2^AW like the reference arithmetic.
  always_ff @(posedge Clk) begin
    if (load) begin
      acc <= AW'(bias) <<< FRAC;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/dense_out.sv
// Final fully connected layer: 10 class scores from 250 pooled activations,
// written to the score RAM, plus the argmax digit and a done pulse.
module dense_out #(
  parameter int N_IN  = nn_pkg::N_IN,
  parameter int N_OUT = nn_pkg::N_OUT,
  parameter int FRAC  = nn_pkg::FRAC
) (
  input  logic        Clk,
  input  logic        Reset,
  dense_out_if.master bus
);

  import nn_pkg::*;

  localparam int IW = $clog2(N_IN);
  localparam int OW = $clog2(N_OUT + 1);

  state_e             state, state_nx;
  logic [IW-1:0]      i;
  logic [OW-1:0]      o;
  logic               vld_p1;
  logic signed [63:0] acc;
  logic signed [31:0] score;
  logic signed [31:0] best_val;
  logic [3:0]         best_idx;
  logic [3:0]         digit_r;
  logic               ready_r;
  logic               last_i;
  logic               last_o;

  assign last_i = (i == IW'(N_IN - 1));
  assign last_o = (o == OW'(N_OUT));
  assign score  = sat32(acc >>> FRAC);

  mac_unit #(.DATA_W(32), .FRAC(FRAC)) u_mac (
    .Clk  (Clk),
    .load (state == LOAD_BIAS),
    .en   (vld_p1),
    .bias (bus.bias_q),
    .a    (bus.temp_q),
    .b    (bus.weight_q),
    .acc  (acc)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.start) state_nx = CHECK_OUT;
      CHECK_OUT: state_nx = last_o ? DONE : LOAD_BIAS;
      LOAD_BIAS: state_nx = MAC;
      MAC:       if (last_i) state_nx = DRAIN;
      DRAIN:     state_nx = SAVE;
      SAVE:      state_nx = CHECK_OUT;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Stage p1: read data for the address issued last cycle is on temp_q/weight_q.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      i       <= '0;
      o       <= '0;
      vld_p1  <= 1'b0;
      ready_r <= 1'b0;
      digit_r <= '0;
    end else begin
      state   <= state_nx;
      vld_p1  <= (state == MAC);
      ready_r <= (state == DONE);
      if (state == MAC) i <= last_i ? '0 : i + IW'(1);
      if (state == SAVE) o <= o + OW'(1);
      if (state == DONE) begin
        o       <= '0;
        digit_r <= best_idx;
      end
    end
  end

  // Strict greater-than keeps the lower index on ties; class 0 seeds the search.
  always_ff @(posedge Clk) begin
    if (state == SAVE && (o == '0 || score > best_val)) begin
      best_val <= score;
      best_idx <= 4'(o);
    end
  end

  assign bus.temp_rdaddr = 14'(i);
  assign bus.weight_addr = 12'(o) * 12'(N_IN) + 12'(i);
  assign bus.bias_addr   = 4'(o);
  assign bus.out_addr    = 4'(o);
  assign bus.out_wren    = (state == SAVE);
  assign bus.out_data    = (state == SAVE) ? score : '0;
  assign bus.digit       = digit_r;
  assign bus.ready       = ready_r;

endmodule
